// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_if
//  Description : Signal bundle between the instruction-fetch unit, the
//                combinational instruction memory and the decode stage.
//                The fetch unit takes the master modport and the
//                surrounding pipeline/IM takes the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface ifu_fetch_if;
    logic        stall;
    logic [1:0]  npc_sel;
    logic [15:0] br_off;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc8;
    logic        if_valid;
    logic        if_err;

    modport master (
        input  stall, npc_sel, br_off, j_index, jr_target, im_instr,
        output im_addr, if_instr, if_pc, if_pc8, if_valid, if_err
    );

    modport slave (
        output stall, npc_sel, br_off, j_index, jr_target, im_instr,
        input  im_addr, if_instr, if_pc, if_pc8, if_valid, if_err
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction-fetch stage. Owns the PC, addresses the
//                zero-latency IM, captures the returned word into the IF/ID
//                register and applies decode-stage redirects with MIPS
//                delay-slot semantics. Bad fetch addresses yield a nop with
//                if_err set.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_DEPTH = 1024
) (
    input  wire logic      clk,
    input  wire logic      reset,
    ifu_fetch_if.master    bus
);

    // 33-bit upper bound so a window ending at 2^32 does not wrap to zero
    localparam logic [32:0] c_IM_LIMIT     = {1'b0, IM_BASE} + 33'(4 * IM_DEPTH);
    localparam logic [31:0] c_PC_RESET_P8  = PC_RESET + 32'd8;

    localparam logic [1:0]  c_SEL_SEQ  = 2'b00;
    localparam logic [1:0]  c_SEL_BR   = 2'b01;
    localparam logic [1:0]  c_SEL_J    = 2'b10;
    localparam logic [1:0]  c_SEL_JR   = 2'b11;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc8;
    logic        r_if_err;

    logic        w_bad;
    logic [31:0] w_capture;
    logic [1:0]  w_sel;
    logic [31:0] w_if_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_pc_nxt;

    // Fetch address check and instruction capture value
    assign w_bad     = (r_pc[1:0] != 2'b00) ||
                       (r_pc < IM_BASE) ||
                       ({1'b0, r_pc} >= c_IM_LIMIT);
    assign w_capture = w_bad ? 32'h0 : bus.im_instr;

    // Redirect targets are computed from the instruction sitting in ID
    assign w_if_pc_plus4 = r_if_pc + 32'd4;
    assign w_br_target   = w_if_pc_plus4 + {{14{bus.br_off[15]}}, bus.br_off, 2'b00};
    assign w_j_target    = {w_if_pc_plus4[31:28], bus.j_index, 2'b00};

    // A redirect from an empty ID stage is meaningless, so force sequential
    assign w_sel = (r_state == S_FETCH) ? bus.npc_sel : c_SEL_SEQ;

    // Next state and next PC; stall freezes both
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (!bus.stall) begin
            w_state_nxt = S_FETCH;
            case (w_sel)
                c_SEL_BR: w_pc_nxt = w_br_target;
                c_SEL_J:  w_pc_nxt = w_j_target;
                c_SEL_JR: w_pc_nxt = bus.jr_target;
                default:  w_pc_nxt = r_pc + 32'd4;
            endcase
        end
    end

    // State register; only reset returns the stage to EMPTY
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC and IF/ID register; the delay-slot word is captured like any other
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= PC_RESET;
            r_if_instr <= 32'h0;
            r_if_pc    <= PC_RESET;
            r_if_pc8   <= c_PC_RESET_P8;
            r_if_err   <= 1'b0;
        end else if (!bus.stall) begin
            r_pc       <= w_pc_nxt;
            r_if_instr <= w_capture;
            r_if_pc    <= r_pc;
            r_if_pc8   <= r_pc + 32'd8;
            r_if_err   <= w_bad;
        end
    end

    assign bus.im_addr  = r_pc;
    assign bus.if_instr = r_if_instr;
    assign bus.if_pc    = r_if_pc;
    assign bus.if_pc8   = r_if_pc8;
    assign bus.if_valid = (r_state == S_FETCH);
    assign bus.if_err   = r_if_err;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Scoreboard bench for ifu_fetch. The stimulus process drives
//                one cycle of inputs and queues the expected post-edge state;
//                the monitor pops and compares on every falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic        valid;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    bit   done;
    exp_t sb[$];

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational IM model: a recognisable word derived from the address
    assign bus.im_instr = bus.im_addr ^ 32'h8C00_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input exp_t e);
        logic [31:0] instr_exp;
        instr_exp = (!e.valid || e.err) ? 32'h0 : (e.ipc ^ 32'h8C00_0000);
        chk("im_addr",  bus.im_addr,  e.pc);
        chk("if_pc",    bus.if_pc,    e.ipc);
        chk("if_pc8",   bus.if_pc8,   e.ipc + 32'd8);
        chk("if_instr", bus.if_instr, instr_exp);
        chk("if_valid", {31'h0, bus.if_valid}, {31'h0, e.valid});
        chk("if_err",   {31'h0, bus.if_err},   {31'h0, e.err});
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ipc,
                        input logic valid, input logic err);
        exp_t e;
        e.pc = pc; e.ipc = ipc; e.valid = valid; e.err = err;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, queue the expected result, move to next cycle
    task automatic step(input logic st, input logic [1:0] sel, input logic [15:0] off,
                        input logic [25:0] idx, input logic [31:0] jr,
                        input logic [31:0] pc, input logic [31:0] ipc,
                        input logic valid, input logic err);
        bus.stall     = st;
        bus.npc_sel   = sel;
        bus.br_off    = off;
        bus.j_index   = idx;
        bus.jr_target = jr;
        push(pc, ipc, valid, err);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare DUT state against the scoreboard after every edge
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            if (sb.size() > 0) check_state(sb.pop_front());
        end
    end

    // Watchdog
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Directed stimulus
    initial begin
        n_tests = 0;
        n_fail  = 0;
        done    = 1'b0;
        reset   = 1'b1;
        bus.stall = 1'b0; bus.npc_sel = 2'b00; bus.br_off = 16'h0;
        bus.j_index = 26'h0; bus.jr_target = 32'h0;
        push(32'h3000, 32'h3000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // sequential start-up
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, 1, 0);
        // backward branch from 0x3008, delay slot 0x300C captured
        step(0, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h3004, 32'h300C, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h300C, 32'h3008, 1, 0);
        // forward branch from 0x3008
        step(0, 2'b01, 16'h0003, 26'h0, 32'h0, 32'h3018, 32'h300C, 1, 0);
        // jr to 0x3010 to line up if_pc=0x3010
        step(0, 2'b11, 16'h0, 26'h0, 32'h3010, 32'h3010, 32'h3018, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3014, 32'h3010, 1, 0);
        // j from if_pc=0x3010
        step(0, 2'b10, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 32'h3014, 1, 0);
        // misaligned jr
        step(0, 2'b11, 16'h0, 26'h0, 32'h3002, 32'h3002, 32'h3040, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3006, 32'h3002, 1, 1);
        step(0, 2'b11, 16'h0, 26'h0, 32'h3020, 32'h3020, 32'h3006, 1, 1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3024, 32'h3020, 1, 0);
        // stall for 3 cycles while a branch is requested
        step(1, 2'b01, 16'h0005, 26'h0, 32'h0, 32'h3024, 32'h3020, 1, 0);
        step(1, 2'b01, 16'h0005, 26'h0, 32'h0, 32'h3024, 32'h3020, 1, 0);
        step(1, 2'b01, 16'h0005, 26'h0, 32'h0, 32'h3024, 32'h3020, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3028, 32'h3024, 1, 0);
        // top of the IM window
        step(0, 2'b11, 16'h0, 26'h0, 32'h3FFC, 32'h3FFC, 32'h3028, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4000, 32'h3FFC, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h4004, 32'h4000, 1, 1);
        // below the IM window
        step(0, 2'b11, 16'h0, 26'h0, 32'h2FFC, 32'h2FFC, 32'h4004, 1, 1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3000, 32'h2FFC, 1, 1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 1, 0);
        // PC wrap at the top of the address space
        step(0, 2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3004, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0004, 32'h0000_0000, 1, 1);

        // asynchronous reset in the middle of a jr redirect cycle
        bus.stall = 1'b0; bus.npc_sel = 2'b11; bus.jr_target = 32'h3100;
        #2;
        reset = 1'b1;
        #1;
        begin
            exp_t e;
            e.pc = 32'h3000; e.ipc = 32'h3000; e.valid = 1'b0; e.err = 1'b0;
            check_state(e);
        end
        push(32'h3000, 32'h3000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3004, 32'h3000, 1, 0);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h3008, 32'h3004, 1, 0);

        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch initiator for the P4 MIPS datapath: owns the PC, drives the byte address into the combinational instruction memory (IM), and captures the returned word into the IF/ID register.
- Accepts next-PC redirects from the decode stage (branch, j/jal, jr) with MIPS delay-slot semantics, honours pipeline stall, and flags out-of-range or misaligned fetches.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
IM_BASE, 32'h0000_3000, byte address of IM word 0
IM_DEPTH, 1024, IM size in 32-bit words; valid range is IM_BASE .. IM_BASE+4*IM_DEPTH-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID register this cycle
npc_sel  in  2  redirect select from ID: 00 seq, 01 branch taken, 10 j/jal, 11 jr
br_off  in  16  branch immediate of the ID-stage instruction
j_index  in  26  jump index of the ID-stage instruction
jr_target  in  32  register value for jr
im_addr  out  32  byte address to IM (combinational = pc)
im_instr  in  32  word returned by IM (combinational)
if_instr  out  32  IF/ID instruction
if_pc  out  32  IF/ID PC
if_pc8  out  32  IF/ID PC+8 (jal link value)
if_valid  out  1  IF/ID holds a fetched instruction
if_err  out  1  IF/ID instruction came from a bad fetch address

Behaviour:
- Reset, asynchronous, any time: pc=PC_RESET, if_instr=0, if_pc=PC_RESET, if_pc8=PC_RESET+8, if_valid=0, if_err=0. Reset mid-stall or mid-redirect discards the pending operation.
- im_addr = pc, purely combinational. IM read latency is zero; the word is captured on the same rising edge that advances pc.
- Fetch check, combinational on pc:
  - bad = (pc[1:0]!=0) or pc<IM_BASE or pc>=IM_BASE+4*IM_DEPTH.
  - When bad, the captured instruction is 32'h0 (nop) and if_err=1; otherwise im_instr is captured and if_err=0.
- Redirect targets are relative to the ID-stage instruction, i.e. if_pc (32-bit arithmetic, wrap modulo 2^32):
  - branch = if_pc + 4 + (sign-extend(br_off) << 2)
  - j = {if_pc_plus4[31:28], j_index, 2'b00}, where if_pc_plus4 = if_pc + 4
  - jr = jr_target, used unmodified; misalignment is caught by the fetch check on the next cycle.
- Next-state on each rising edge (priority reset > stall > redirect > sequential):
  - stall=1: pc and every IF/ID output hold. npc_sel is ignored; ID re-presents it after the stall.
  - stall=0: IF/ID <= {captured instr, pc, pc+8, valid=1, err=bad}.
  - stall=0: pc <= target per npc_sel, or pc+4 when npc_sel=00.
  - npc_sel is meaningful only when if_valid=1. When if_valid=0, treat npc_sel as 00.
- Delay slot: the instruction fetched in the redirect cycle (at pc = if_pc+4) is captured normally and is never flushed.
- State machine, 2 states:
  - EMPTY (after reset, if_valid=0) -> FETCH on the first non-stalled edge.
  - FETCH -> FETCH. Only reset returns the block to EMPTY.
- Simultaneous stall and non-zero npc_sel: stall wins, with no pc change.
- pc increments wrap 32'hFFFF_FFFC -> 0. Such addresses raise if_err under the default range check.

Test Plan:
- Reset asserted, then released; run 3 unstalled cycles -> im_addr 0x3000, 0x3004, 0x3008; if_pc follows one cycle behind; if_valid rises after the first edge; if_pc8 = if_pc+8.
- With if_pc=0x3008: npc_sel=01, br_off=16'hFFFE -> delay-slot fetch at 0x300C is captured, then pc=0x3004. Repeat with br_off=16'h0003 -> pc=0x3018.
- With if_pc=0x3010: npc_sel=10, j_index=26'h0000C10 -> next pc=0x3040. Then npc_sel=11, jr_target=0x3002 -> im_addr 0x3002; captured if_instr=0 with if_err=1.
- stall held 3 cycles while npc_sel=01 -> pc, if_instr and if_pc unchanged for all 3 cycles. On release with npc_sel=00, pc advances by exactly 4.
- Sequential run from pc=IM_BASE+4*IM_DEPTH-4 -> last word captured with if_err=0; the next fetch at 0x4000 (defaults) gives if_instr=0, if_err=1.
- Reset asserted asynchronously mid-cycle during a jr redirect -> outputs return to their reset values immediately, before the next clock edge; the first fetch after release is at 0x3000.
